// File: rtl/fp16_div_seq.sv
`timescale 1ns/1ps
// Sequential FP16 divider: radix-2 restoring mantissa divide, one
// quotient bit per cycle, truncating, subnormals flushed to zero.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/a/b operand
// handshake, out_valid/out_ready/result quotient handshake, and the
// flag_invalid/flag_dz/flag_ovf/flag_unf status flags for the result.
module fp16_div_seq #(
    parameter int BIAS  = 15,
    parameter int QBITS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        flag_invalid,
    output logic        flag_dz,
    output logic        flag_ovf,
    output logic        flag_unf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic             sign_q;
    logic [4:0]       ea_q;
    logic [4:0]       eb_q;
    logic [10:0]      mb_q;
    logic [QBITS-1:0] rem_q;
    logic [QBITS-1:0] quo_q;
    logic [3:0]       cnt_q;
    logic             spec_q;

    // operand classification
    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;
    logic sgn;

    assign a_zero = (a[14:10] == 5'd0);
    assign a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    assign a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    assign b_zero = (b[14:10] == 5'd0);
    assign b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    assign b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    assign sgn    = a[15] ^ b[15];

    // special-case outcome, flags ordered {invalid, dz, ovf, unf}
    logic        spec;
    logic [15:0] spec_res;
    logic [3:0]  spec_flg;

    always_comb begin
        spec     = 1'b1;
        spec_res = 16'h0000;
        spec_flg = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = 16'h7E00;
            spec_flg = 4'b1000;
        end else if (a_inf) begin
            spec_res = {sgn, 5'h1F, 10'h0};
        end else if (b_zero) begin
            spec_res = {sgn, 5'h1F, 10'h0};
            spec_flg = 4'b0100;
        end else if (a_zero || b_inf) begin
            spec_res = {sgn, 15'h0};
        end else begin
            spec = 1'b0;
        end
    end

    // one restoring step
    logic             ge;
    logic [QBITS-1:0] rem_sub;
    logic [QBITS-1:0] rem_nxt;

    assign ge      = (rem_q >= QBITS'(mb_q));
    assign rem_sub = ge ? (rem_q - QBITS'(mb_q)) : rem_q;
    assign rem_nxt = rem_sub << 1;

    // normalisation: quotient lies in [1024, 4096)
    logic signed [6:0] e_n;
    logic [9:0]        mant;

    assign e_n  = 7'({2'b00, ea_q}) - 7'({2'b00, eb_q}) + 7'(BIAS)
                - {6'd0, ~quo_q[QBITS-1]};
    assign mant = quo_q[QBITS-1] ? quo_q[10:1] : quo_q[9:0];

    assign in_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            out_valid    <= 1'b0;
            result       <= 16'h0000;
            flag_invalid <= 1'b0;
            flag_dz      <= 1'b0;
            flag_ovf     <= 1'b0;
            flag_unf     <= 1'b0;
            cnt_q        <= 4'd0;
            sign_q       <= 1'b0;
            ea_q         <= 5'd0;
            eb_q         <= 5'd0;
            mb_q         <= 11'd0;
            rem_q        <= '0;
            quo_q        <= '0;
            spec_q       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q <= sgn;
                        ea_q   <= a[14:10];
                        eb_q   <= b[14:10];
                        mb_q   <= {1'b1, b[9:0]};
                        rem_q  <= QBITS'({1'b1, a[9:0]});
                        quo_q  <= '0;
                        cnt_q  <= 4'd0;
                        spec_q <= spec;
                        {flag_invalid, flag_dz, flag_ovf, flag_unf} <= spec_flg;
                        if (spec) begin
                            result <= spec_res;
                            state  <= S_NORM;
                        end else begin
                            state  <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[QBITS-2:0], ge};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(QBITS - 1))
                        state <= S_NORM;
                end
                S_NORM: begin
                    if (!spec_q) begin
                        if (e_n >= 7'sd31) begin
                            result   <= {sign_q, 5'h1F, 10'h0};
                            flag_ovf <= 1'b1;
                        end else if (e_n <= 7'sd0) begin
                            result   <= {sign_q, 15'h0};
                            flag_unf <= 1'b1;
                        end else begin
                            result <= {sign_q, e_n[4:0], mant};
                        end
                    end
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_div_seq.sv
`timescale 1ns/1ps
// Directed bench for fp16_div_seq: result, flags, latency,
// backpressure and mid-divide reset.
module tb_fp16_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
    logic        flag_invalid, flag_dz, flag_ovf, flag_unf;
    logic [3:0]  flags;

    assign flags = {flag_invalid, flag_dz, flag_ovf, flag_unf};

    fp16_div_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_invalid(flag_invalid), .flag_dz(flag_dz),
        .flag_ovf(flag_ovf), .flag_unf(flag_unf)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge while in_ready is high.
    task automatic run_op(input string tag, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] er,
                          input logic [3:0] ef, input int elat);
        int lat;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " lat"}, lat, elat);
        check({tag, " res"}, result, er);
        check({tag, " flg"}, flags, ef);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " ov0"}, out_valid, 1'b0);
        check({tag, " rdy"}, in_ready, 1'b1);
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1;
        check("rst res", result, 16'h0);
        check("rst flg", flags, 4'h0);
        check("rst ov", out_valid, 1'b0);
        rst_n = 1'b1;
        check("rst rdy", in_ready, 1'b1);

        // flags: {invalid, dz, ovf, unf}
        run_op("1/1",     16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 13);
        run_op("1/3",     16'h3C00, 16'h4200, 16'h3555, 4'b0000, 13);
        run_op("6/2",     16'h4600, 16'h4000, 16'h4200, 4'b0000, 13);
        run_op("-6/2",    16'hC600, 16'h4000, 16'hC200, 4'b0000, 13);
        run_op("ovf",     16'h7BFF, 16'h3800, 16'h7C00, 4'b0010, 13);
        run_op("unf",     16'h3C00, 16'h7BFF, 16'h0000, 4'b0001, 13);
        run_op("dz",      16'hC000, 16'h0000, 16'hFC00, 4'b0100, 1);
        run_op("0/0",     16'h0000, 16'h0000, 16'h7E00, 4'b1000, 1);
        run_op("inf/1",   16'h7C00, 16'h3C00, 16'h7C00, 4'b0000, 1);
        run_op("1/-inf",  16'h3C00, 16'hFC00, 16'h8000, 4'b0000, 1);
        run_op("sub/1",   16'h0001, 16'h3C00, 16'h0000, 4'b0000, 1);
        run_op("nan",     16'h7E01, 16'h3C00, 16'h7E00, 4'b1000, 1);
        run_op("inf/inf", 16'hFC00, 16'h7C00, 16'h7E00, 4'b1000, 1);

        // backpressure, operands changed mid-divide
        a = 16'h4600;
        b = 16'h4000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'h0000;
        b = 16'h7E00;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp lat", lat, 13);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp res", result, 16'h4200);
            check("bp flg", flags, 4'b0000);
            check("bp ov", out_valid, 1'b1);
            check("bp rdy", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp ov0", out_valid, 1'b0);
        check("bp rdy1", in_ready, 1'b1);

        // reset in the 6th DIV cycle
        a = 16'h3C00;
        b = 16'h4200;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mr ov", out_valid, 1'b0);
        check("mr rdy", in_ready, 1'b1);
        check("mr res", result, 16'h0);
        run_op("post", 16'h4600, 16'h4000, 16'h4200, 4'b0000, 13);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
